// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Round-robin arbiter that merges N valid/ready/last packet sources onto a
//   single registered output stage. A granted source owns the output until
//   the beat carrying its last flag is accepted, so packets never interleave.
//
// Parameters
//   LEN   data width per beat
//   N     number of sources (2..8)
//   IW    source index width, $clog2(N)
//
// Ports
//   clk      single rising-edge clock
//   rst      synchronous reset, active low
//   s_valid  per-source beat valid
//   s_last   per-source end-of-packet, qualified by s_valid
//   s_data   packed source data, source i at [i*LEN +: LEN]
//   s_ready  per-source ready, at most one bit high
//   m_valid  registered output valid
//   m_last   registered output end-of-packet
//   m_data   registered output data
//   m_src    registered index of the source that produced m_data
//   m_ready  sink ready
module stream_rr_arbiter #(
  parameter  int LEN = 8,
  parameter  int N   = 4,
  localparam int IW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s_valid,
  input  logic [N-1:0]     s_last,
  input  logic [N*LEN-1:0] s_data,
  output logic [N-1:0]     s_ready,
  output logic             m_valid,
  output logic             m_last,
  output logic [LEN-1:0]   m_data,
  output logic [IW-1:0]    m_src,
  input  logic             m_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [LEN-1:0]  m_data_q, m_data_d;
  logic [IW-1:0]   m_src_q, m_src_d;

  // Lane view of the packed source data bus.
  logic [N-1:0][LEN-1:0] s_data_lane;
  assign s_data_lane = s_data;

  logic busy;
  logic out_free;
  logic acc;

  assign busy     = (state_q == BUSY);
  // Output register can take a new beat when empty or draining this cycle.
  // This is the only path from m_ready to s_ready.
  assign out_free = !m_valid_q || m_ready;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign s_ready[i] = busy && out_free && (grant_q == IW'(i));
  end

  assign acc = busy && out_free && s_valid[grant_q];

  // Cyclic priority search starting at rr_ptr. cand is one bit wider so the
  // sum rr_ptr + k (at most 2N-2) never overflows before the wrap.
  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;

  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && s_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;

    // Sink took the held beat; payload fields keep their old values.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_lane[grant_q];
          m_last_d  = s_last[grant_q];
          m_src_d   = grant_q;
          if (s_last[grant_q]) begin
            state_d  = IDLE;
            // Start the next search just past the finished source so it
            // ends up with the lowest priority.
            rr_ptr_d = (grant_q == IW'(N-1)) ? '0 : grant_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(s_ready));

  // A stalled output beat must not change.
  a_out_hold: assert property (@(posedge clk)
    (rst && m_valid && !m_ready) |=>
      (m_valid && $stable(m_data) && $stable(m_last) && $stable(m_src)));

endmodule
